// File: rtl/fa_64_bit_seq_pkg.sv
// Shared ALU definitions for the sequential 64-bit adder.
// Holds the datapath width, FSM states and the digit-width check.
package fa_64_bit_seq_pkg;

    localparam int DATA_W = 64;
    localparam int IDX_W  = $clog2(DATA_W);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // A digit width is usable when it is a power of two dividing DATA_W.
    function automatic bit w_legal(input int w);
        return (w > 0) && (w <= DATA_W) &&
               ((DATA_W % w) == 0) && ((w & (w - 1)) == 0);
    endfunction

endpackage

// File: rtl/fa_64_bit_seq_digit.sv
// Combinational W-bit ripple full adder for one digit.
// cmsb is the carry entering the top bit, used for signed overflow.
module fa_digit #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] s,
    output logic         cout,
    output logic         cmsb
);

    logic [W:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < W; i++) begin : g_bit
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout = c[W];
    assign cmsb = c[W-1];

endmodule

// File: rtl/fa_64_bit_seq.sv
// Multi-cycle 64-bit adder: Sum = A + B + Cin, one W-bit digit per
// clock, least-significant digit first, with a registered carry.
module fa_64_bit_seq
    import fa_64_bit_seq_pkg::*;
#(
    parameter int W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    input  logic              Cin,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] Sum,
    output logic              Cout,
    output logic              Ovf
);

    localparam int N  = DATA_W / W;
    localparam int KW = (N > 1) ? $clog2(N) : 1;

    if (!w_legal(W)) begin : g_bad_w
        $error("fa_64_bit_seq: W must be a power of two dividing 64");
    end

    state_t            state;
    state_t            state_nxt;

    logic [DATA_W-1:0] a_r;
    logic [DATA_W-1:0] b_r;
    logic [DATA_W-1:0] sum_r;
    logic [DATA_W-1:0] sum_nxt;
    logic              carry_r;
    logic              cout_r;
    logic              ovf_r;
    logic              done_r;
    logic [KW-1:0]     k;
    logic              last;

    logic [W-1:0]      da;
    logic [W-1:0]      db;
    logic [W-1:0]      ds;
    logic              dcout;
    logic              dcmsb;

    assign last = (k == KW'(N - 1));

    if (N == 1) begin : g_one
        // Single digit covers the whole word; no digit selection needed.
        always_comb begin
            da      = a_r;
            db      = b_r;
            sum_nxt = ds;
        end
    end else begin : g_multi
        logic [IDX_W-1:0] base;

        // Select digit k of the operands and merge the new digit into Sum.
        always_comb begin
            base             = IDX_W'(int'(k) * W);
            da               = a_r[base +: W];
            db               = b_r[base +: W];
            sum_nxt          = sum_r;
            sum_nxt[base +: W] = ds;
        end
    end

    fa_digit #(
        .W    (W)
    ) u_digit (
        .a    (da),
        .b    (db),
        .cin  (carry_r),
        .s    (ds),
        .cout (dcout),
        .cmsb (dcmsb)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: start leaves IDLE, last digit returns to IDLE.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (last) begin
                    state_nxt = IDLE;
                end
            end
        endcase
    end

    // FSM outputs.
    always_comb begin
        busy = (state == RUN);
    end

    // Operand capture, digit accumulation and result flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_r     <= '0;
            b_r     <= '0;
            sum_r   <= '0;
            carry_r <= 1'b0;
            cout_r  <= 1'b0;
            ovf_r   <= 1'b0;
            done_r  <= 1'b0;
            k       <= '0;
        end else begin
            done_r <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        a_r     <= A;
                        b_r     <= B;
                        carry_r <= Cin;
                        sum_r   <= '0;
                        cout_r  <= 1'b0;
                        ovf_r   <= 1'b0;
                        k       <= '0;
                    end
                end
                RUN: begin
                    sum_r   <= sum_nxt;
                    carry_r <= dcout;
                    if (last) begin
                        k      <= '0;
                        cout_r <= dcout;
                        ovf_r  <= dcmsb ^ dcout;
                        done_r <= 1'b1;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
            endcase
        end
    end

    assign done = done_r;
    assign Sum  = sum_r;
    assign Cout = cout_r;
    assign Ovf  = ovf_r;

endmodule

// File: doc/fa_64_bit_seq.md
# fa_64_bit_seq

Multi-cycle 64-bit full adder for the ALU: computes Sum = A + B + Cin one W-bit digit per clock, least-significant digit first, with a registered carry between digits. It is the addition-side counterpart of the ALU's 64-bit full subtractor (Diff = A − B − Bin). It targets pipeline configurations where a single-cycle 64-bit ripple path does not close timing. A start/busy/done handshake connects it to the EX-stage control, which stalls while busy is high.

## Interface
- W, default 8, digit width in bits processed per cycle. Must divide 64; legal values are 1, 2, 4, 8, 16, 32, 64.
- N, derived constant 64/W (not overridable), number of RUN cycles.
- clk  input  1  rising-edge clock; the block's single clock.
- rst  input  1  reset, synchronous and active-high.
- start  input  1  request; sampled only in IDLE.
- A  input  64  addend; sampled with start.
- B  input  64  addend; sampled with start.
- Cin  input  1  carry-in; sampled with start.
- busy  output  1  high while an operation is in progress (state RUN).
- done  output  1  single-cycle pulse when Sum, Cout and Ovf become valid.
- Sum  output  64  result, registered.
- Cout  output  1  carry out of bit 63.
- Ovf  output  1  signed overflow: carry into bit 63 XOR carry out of bit 63.

## Operation
- FSM with two states, IDLE and RUN. Reset state is IDLE.
- **IDLE with start=1:**
  - Latch A, B and Cin into operand registers; Cin becomes the carry register.
  - Clear the digit counter k to 0.
  - Go to RUN.
- **IDLE with start=0:** hold all registers.
- **Each RUN cycle:**
  - Digit k: {c, Sum[k*W +: W]} = A_r[k*W +: W] + B_r[k*W +: W] + carry; store c in the carry register.
  - Other Sum bits are unchanged.
  - k increments.
- **Last RUN cycle (k = N−1):**
  - Cout = final carry.
  - Ovf = carry into bit 63 XOR Cout.
  - done set to 1 for the next cycle.
  - Go to IDLE.
- Sum is cleared to 0 at start acceptance. Sum, Cout and Ovf are valid only from the done pulse onward. They hold until the next accepted start.
- start during RUN is ignored; operands are not re-sampled.
- **Reset values:** busy=0, done=0, Sum=0, Cout=0, Ovf=0, k=0, state IDLE.
- **Reset mid-operation:** the operation is aborted with no done pulse, and all outputs return to reset values on the next edge.
- Wrap-around is modulo 2^64; there is no saturation.
- With W=64 the block degenerates to one RUN cycle.

## Timing
- start sampled high at edge E0 (in IDLE): busy is high from E0 through E0+N; done is high for exactly one cycle following edge E0+N.
- Latency is N cycles from start acceptance to done: 8 cycles with W=8.
- busy falls on the same edge that done rises.
- start high while done is high is accepted, because the state is IDLE. The minimum start-to-start spacing is therefore N+1 cycles.
- rst takes priority over start at every edge.

## Structure
- **Shared ALU package:**
  - DATA_W = 64.
  - State enum {IDLE, RUN}.
  - Legal-W check function.
- **Sub-module fa_digit:** combinational W-bit ripple full adder with ports a, b, cin, s, cout, plus cmsb (carry into its MSB), used for Ovf.
- **Top level:** FSM, counter of $clog2(N) bits (minimum 1), operand/carry/result registers.

## Test plan
- A=0xFFFF_FFFF_FFFF_FFFF, B=0, Cin=1, W=8 → after 8 cycles done=1, Sum=0, Cout=1, Ovf=0.
- A=0x7FFF_FFFF_FFFF_FFFF, B=1, Cin=0 → Sum=0x8000_0000_0000_0000, Cout=0, Ovf=1.
- Start accepted (A=5, B=3, Cin=0), then start pulsed in RUN cycle 3 with A=1, B=1 → single done, Sum=8; busy never drops early.
- rst asserted in RUN cycle 4 → next edge busy=0, Sum=0, no done pulse; a following start (A=2, B=2) gives Sum=4 after 8 cycles.
- start held high continuously with fixed operands → done pulses every 9 cycles, with identical results each time.
- 1000 random A/B/Cin for W ∈ {1, 8, 16, 64} → Sum, Cout and Ovf match the 65-bit reference sum; latency is exactly 64/W cycles.
